// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, GF(2^8) helpers, S-boxes and the
// column-major 4x4 byte state type used by the encrypt and decrypt datapaths.
package aes_pkg;

  localparam int NR = 10;

  // Element [c][r] holds byte 4*c+r; byte 0 sits in bits [127:120].
  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPAND,
    S_INIT,
    S_ROUND,
    S_DONE
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Inverse computed as a^254, which also maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input logic [2:0] n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 3'd1) ^ rotl8(b, 3'd2) ^ rotl8(b, 3'd3) ^ rotl8(b, 3'd4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 3'd1) ^ rotl8(a, 3'd3) ^ rotl8(a, 3'd6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic state_t to_state(input logic [127:0] v);
    return state_t'(v);
  endfunction

  function automatic logic [127:0] from_state(input state_t s);
    return 128'(s);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless 'last' selects the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  state_t s, k, t, m;

  function automatic logic [31:0] inv_mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] a3);
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  always_comb begin
    s = to_state(state_in);
    k = to_state(round_key);
    t = '0;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      // Row r is rotated right by r columns, so column c takes from column c-r.
      for (int r = 0; r < 4; r++) begin
        t[2'(c)][2'(r)] = inv_sbox(s[2'(c - r)][2'(r)]) ^ k[2'(c)][2'(r)];
      end
      m[2'(c)] = inv_mix_col(t[2'(c)][0], t[2'(c)][1], t[2'(c)][2], t[2'(c)][3]);
    end
    state_out = last ? from_state(t) : from_state(m);
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: one round per clock through a shared round
// datapath, with a single cached key schedule reused when the key repeats.
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_ciphertext,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_plaintext,
  output logic         key_hit
);

  fsm_t         fsm, fsm_next;
  logic [3:0]   rnd;
  logic         keys_valid;
  logic [127:0] rk [0:NR];
  logic [127:0] blk;
  logic         accept, hit;
  logic [127:0] prev_rk, rk_next, round_out;
  logic [31:0]  temp, w0, w1, w2, w3;

  assign accept    = in_ready && in_valid;
  assign hit       = keys_valid && (in_key == rk[0]);
  assign out_valid = (fsm == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= S_IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      S_IDLE:   if (accept) fsm_next = hit ? S_INIT : S_EXPAND;
      S_EXPAND: if (rnd == 4'(NR)) fsm_next = S_INIT;
      S_INIT:   fsm_next = S_ROUND;
      S_ROUND:  if (rnd == 4'd0) fsm_next = S_DONE;
      S_DONE:   if (out_ready) fsm_next = S_IDLE;
      default:  fsm_next = S_IDLE;
    endcase
  end

  // Forward key schedule step: derives rk[rnd] from rk[rnd-1].
  always_comb begin
    prev_rk = rk[rnd - 4'd1];
    temp    = {sbox(prev_rk[23:16]), sbox(prev_rk[15:8]), sbox(prev_rk[7:0]),
               sbox(prev_rk[31:24])} ^ {rcon(rnd), 24'h0};
    w0      = prev_rk[127:96] ^ temp;
    w1      = prev_rk[95:64] ^ w0;
    w2      = prev_rk[63:32] ^ w1;
    w3      = prev_rk[31:0] ^ w2;
    rk_next = {w0, w1, w2, w3};
  end

  aes_inv_round u_round (
    .state_in  (blk),
    .round_key (rk[rnd]),
    .last      (rnd == 4'd0),
    .state_out (round_out)
  );

  // Control state, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready      <= 1'b0;
      rnd           <= '0;
      keys_valid    <= 1'b0;
      key_hit       <= 1'b0;
      out_plaintext <= '0;
    end else begin
      in_ready <= (fsm_next == S_IDLE);
      case (fsm)
        S_IDLE: begin
          if (accept) begin
            key_hit <= hit;
            rnd     <= 4'd1;
            if (!hit) keys_valid <= 1'b0;
          end
        end
        S_EXPAND: begin
          if (rnd == 4'(NR)) keys_valid <= 1'b1;
          else               rnd        <= rnd + 4'd1;
        end
        S_INIT:   rnd <= 4'(NR - 1);
        S_ROUND: begin
          if (rnd != 4'd0) rnd           <= rnd - 4'd1;
          else             out_plaintext <= round_out;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; rk[0] doubles as the cached cipher key.
  always_ff @(posedge clk) begin
    case (fsm)
      S_IDLE: begin
        if (accept) begin
          blk <= in_ciphertext;
          if (!hit) rk[0] <= in_key;
        end
      end
      S_EXPAND: rk[rnd] <= rk_next;
      S_INIT:   blk     <= blk ^ rk[NR];
      S_ROUND:  blk     <= round_out;
      default: ;
    endcase
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 inverse cipher: accepts a 128-bit ciphertext and key over a valid/ready handshake and returns the plaintext over a second valid/ready handshake. It is the decrypt-side counterpart of the unrolled combinational encrypt datapath. It trades throughput for area: one round per clock and a single shared round datapath. A one-entry round-key cache skips re-expansion when consecutive blocks use the same key.

## Interface
- No parameters. AES-128 only; Nr = 10 is fixed in the package.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ciphertext/key offered
- in_ready  out  1  block can accept; high only in IDLE
- in_ciphertext  in  128  byte 0 = bits [127:120], FIPS-197 column-major order
- in_key  in  128  cipher key, same byte order
- out_valid  out  1  plaintext valid; held until accepted
- out_ready  in  1  downstream accepts
- out_plaintext  out  128  result; stable while out_valid=1
- key_hit  out  1  qualifies out_valid: 1 when the cached key schedule was reused for this block

## Operation
- States: IDLE, EXPAND, INIT, ROUND, DONE.
- IDLE: in_ready=1. When in_valid=1, capture ciphertext and key.
  - Hit (keys_valid=1 and in_key equals cached key): go to INIT.
  - Miss: go to EXPAND with rk[0]=in_key, write the cached key, clear keys_valid.
- EXPAND: 10 cycles. Forward key schedule, one round key per cycle (RotWord, SubWord, Rcon[r]) into rk[1..10]. After rk[10] is written, set keys_valid=1 and go to INIT.
- INIT: 1 cycle. state ← ct ^ rk[10]. Set r=9 and go to ROUND.
- ROUND: 10 cycles, r = 9 down to 0.
  - r ≥ 1: state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
  - r = 0: InvMixColumns is bypassed. The result goes to out_plaintext, then DONE.
- DONE: out_valid=1. When out_ready=1, go to IDLE. key_hit is registered at accept time and held through DONE.
- All arithmetic is GF(2^8) with polynomial 0x11B. The round counter is 4 bits and never wraps below 0.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after deassertion; out_valid=0, out_plaintext=0, key_hit=0, keys_valid=0, state=IDLE.
- Accept cycle = cycle 0.
  - Miss: out_valid rises at cycle 22 (10 EXPAND + 1 INIT + 10 ROUND + 1 DONE-entry register).
  - Hit: out_valid rises at cycle 12.
- The out_valid=1 and out_ready=1 cycle is the transfer. in_ready rises the next cycle, so back-to-back blocks have 1 idle cycle minimum.
- out_ready asserted before out_valid has no effect. out_valid never drops without a transfer.
- in_valid outside IDLE is ignored. No input is captured, and in_ciphertext/in_key may change freely.
- rst_n low mid-operation aborts immediately: all outputs return to reset values, keys_valid is cleared, and the next block is treated as a miss.
- No combinational path from any input to any output.

## Structure
- Shared package aes_pkg holds:
  - NR=10 and the Rcon table
  - forward S-box and inverse S-box functions
  - xtime/gmul helpers
  - the state typedef (4x4 byte array) with pack/unpack functions matching the 128-bit byte order
- The encrypt side uses the same package.
- Sub-module aes_inv_round: combinational InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns, with a `last` bypass input for InvMixColumns. Instantiated once.
- The key-schedule step (one word-group per cycle) stays inline in the top FSM.
- The rk[0..10] register file is 1408 bits.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt 00112233445566778899aabbccddeeff; out_valid 22 cycles after accept; key_hit=0.
- Same key again, ct from FIPS-197 Appendix B is invalid with this key, so resend the C.1 ct → same pt; latency 12; key_hit=1.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734; key_hit=0 (key change forces re-expansion).
- Backpressure: hold out_ready=0 for 50 cycles after out_valid → out_valid and out_plaintext stable, in_ready=0 throughout, in_valid pulses ignored; release → single transfer, in_ready=1 next cycle.
- Reset at cycle 5 of EXPAND, then resubmit C.1 → all outputs zero during reset; correct pt with key_hit=0 and latency 22.
- Random: 1000 blocks, random keys with 50% repeat probability, random out_ready → every pt matches the encrypt-datapath reference model; key_hit matches repeat history.
